// File: rtl/td4_mem_loader.sv
// td4_mem_loader: program loader and memory-port arbiter for the TD4
// 16 x 8-bit program memory. In RUN the CPU program counter drives the
// memory address; a rising edge on load_req starts a nibble-serial load
// (opcode nibble, then immediate nibble) of words 0..15, after which the
// CPU receives a one-cycle restart pulse.
// Optional feature macro: LOADER_CHECKSUM_EN appends a two-nibble checksum
// (low nibble first) that is compared against the byte-wise sum of the load.
module td4_mem_loader #(
    parameter int WORDS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_req,
    input  logic [3:0] nib_in,
    input  logic       nib_valid,
    output logic       nib_ready,
    input  logic [3:0] cpu_pc,
    output logic [3:0] mem_address,
    output logic [3:0] mem_opcode_in,
    output logic [3:0] mem_immediate_in,
    output logic       mem_write,
    output logic       cpu_hold,
    output logic       cpu_restart,
    output logic       load_err
);

    localparam logic [3:0] LAST_ADDR = 4'(WORDS - 1);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        RUN, GET_OP, GET_IMM, WRITE, DONE, GET_CK_LO, GET_CK_HI, ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        RUN, GET_OP, GET_IMM, WRITE, DONE
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [3:0]  addr_q, addr_d;
    logic        load_req_q;
    logic [3:0]  op_q;
    logic [3:0]  imm_q;
    logic        load_start;
    logic        xfer;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  ck_q;
    logic [3:0]  ck_lo_q;
`endif

    assign load_start = load_req & ~load_req_q;
    assign xfer       = nib_valid & nib_ready;

    // Output decode from the registered state only.
    always_comb begin
        nib_ready   = 1'b0;
        mem_write   = 1'b0;
        cpu_restart = 1'b0;
        load_err    = 1'b0;
        cpu_hold    = (state_q != RUN);
        mem_address = (state_q == RUN) ? cpu_pc : addr_q;
        case (state_q)
            GET_OP, GET_IMM: nib_ready = 1'b1;
            WRITE:           mem_write = 1'b1;
            DONE:            cpu_restart = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            GET_CK_LO, GET_CK_HI: nib_ready = 1'b1;
            ERR:             load_err = 1'b1;
`endif
            default: ;
        endcase
    end

    assign mem_opcode_in    = op_q;
    assign mem_immediate_in = imm_q;

    // Next-state logic: load_req low aborts a nibble wait before any transfer.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            RUN: begin
                if (load_start) begin
                    addr_d  = 4'd0;
                    state_d = GET_OP;
                end
            end
            GET_OP: begin
                if (!load_req)  state_d = DONE;
                else if (xfer)  state_d = GET_IMM;
            end
            GET_IMM: begin
                if (!load_req)  state_d = DONE;
                else if (xfer)  state_d = WRITE;
            end
            WRITE: begin
                if (addr_q == LAST_ADDR) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = GET_CK_LO;
`else
                    state_d = DONE;
`endif
                end else begin
                    addr_d  = addr_q + 4'd1;
                    state_d = GET_OP;
                end
            end
            DONE: state_d = RUN;
`ifdef LOADER_CHECKSUM_EN
            GET_CK_LO: begin
                if (!load_req)  state_d = DONE;
                else if (xfer)  state_d = GET_CK_HI;
            end
            GET_CK_HI: begin
                if (!load_req)  state_d = DONE;
                else if (xfer)  state_d = ({nib_in, ck_lo_q} == ck_q) ? DONE : ERR;
            end
            ERR: begin
                if (load_start) begin
                    addr_d  = 4'd0;
                    state_d = GET_OP;
                end
            end
`endif
            default: state_d = RUN;
        endcase
    end

    // Control state: asynchronous reset returns to RUN with no pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            addr_q     <= 4'd0;
            load_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            load_req_q <= load_req;
        end
    end

    // Data capture: nibbles and running checksum need no reset.
    always_ff @(posedge clk) begin
        if (state_q == GET_OP && xfer)  op_q  <= nib_in;
        if (state_q == GET_IMM && xfer) imm_q <= nib_in;
`ifdef LOADER_CHECKSUM_EN
        if (load_start && (state_q == RUN || state_q == ERR)) ck_q <= 8'd0;
        else if (state_q == WRITE)                            ck_q <= ck_q + {imm_q, op_q};
        if (state_q == GET_CK_LO && xfer) ck_lo_q <= nib_in;
`endif
    end

endmodule

// File: tb/tb_td4_mem_loader.sv
// Testbench for td4_mem_loader: randomized nibble stream with a scoreboard
// of expected memory writes and a reference memory image.
module tb_td4_mem_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_req;
    logic [3:0] nib_in;
    logic       nib_valid;
    logic       nib_ready;
    logic [3:0] cpu_pc;
    logic [3:0] mem_address;
    logic [3:0] mem_opcode_in;
    logic [3:0] mem_immediate_in;
    logic       mem_write;
    logic       cpu_hold;
    logic       cpu_restart;
    logic       load_err;

    td4_mem_loader #(.WORDS(16)) dut (
        .clk(clk), .rst_n(rst_n), .load_req(load_req),
        .nib_in(nib_in), .nib_valid(nib_valid), .nib_ready(nib_ready),
        .cpu_pc(cpu_pc), .mem_address(mem_address),
        .mem_opcode_in(mem_opcode_in), .mem_immediate_in(mem_immediate_in),
        .mem_write(mem_write), .cpu_hold(cpu_hold),
        .cpu_restart(cpu_restart), .load_err(load_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] exp_q[$];          // {address, {imm,op}} of expected writes
    logic [7:0]  exp_mem[16];       // reference memory image
    logic [7:0]  obs_mem[16];       // image rebuilt from observed writes
    int          exp_restarts = 0;
    int          obs_restarts = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, req, req, $time);
        end
    endtask

    // Monitor: every observed write is popped from the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_write) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    logic [11:0] e;
                    e = exp_q.pop_front();
                    check("write_addr", int'(mem_address), int'(e[11:8]));
                    check("write_data", int'({mem_immediate_in, mem_opcode_in}), int'(e[7:0]));
                end
                check("hold_during_write", int'(cpu_hold), 1);
                check("ready_low_in_write", int'(nib_ready), 0);
                obs_mem[mem_address] = {mem_immediate_in, mem_opcode_in};
            end
            if (cpu_restart) obs_restarts++;
        end
    end

    task automatic send_nib(input logic [3:0] n, input bit rnd);
        int  guard = 0;
        bit  done  = 0;
        while (!done) begin
            @(negedge clk);
            nib_in    = n;
            nib_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (nib_valid && nib_ready) begin
                @(posedge clk);
                done = 1;
            end else begin
                guard++;
                if (guard > 100) begin
                    check("nibble_accept_timeout", 0, 1);
                    done = 1;
                end
            end
        end
    endtask

    task automatic send_word(input int addr, input logic [7:0] b, input bit rnd);
        send_nib(b[3:0], rnd);
        send_nib(b[7:4], rnd);
        exp_q.push_back({4'(addr), b});
        exp_mem[addr] = b;
    endtask

    task automatic start_load();
        @(negedge clk);
        load_req  = 1'b0;
        nib_valid = 1'b0;
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        check("hold_after_start", int'(cpu_hold), 1);
        check("err_clear_after_start", int'(load_err), 0);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_run_state(input string tag);
        check({tag, "_hold"}, int'(cpu_hold), 0);
        check({tag, "_restarts"}, obs_restarts, exp_restarts);
        check({tag, "_pending_writes"}, exp_q.size(), 0);
        for (int k = 0; k < 2; k++) begin
            cpu_pc = 4'($urandom_range(0, 15));
            #1;
            check({tag, "_pc_passthru"}, int'(mem_address), int'(cpu_pc));
        end
    endtask

    task automatic check_mem(input string tag);
        int bad = 0;
        for (int k = 0; k < 16; k++)
            if (obs_mem[k] !== exp_mem[k]) bad++;
        check({tag, "_mem_words_wrong"}, bad, 0);
    endtask

    task automatic full_load(input logic [7:0] b[16], input bit rnd, input bit bad_ck);
        logic [7:0] ck = 8'd0;
        start_load();
        for (int k = 0; k < 16; k++) begin
            send_word(k, b[k], rnd);
            ck = ck + b[k];
        end
`ifdef LOADER_CHECKSUM_EN
        if (bad_ck) ck = ck + 8'd1;
        send_nib(ck[3:0], rnd);
        send_nib(ck[7:4], rnd);
        if (!bad_ck) exp_restarts++;
`else
        exp_restarts++;
`endif
        @(negedge clk);
        nib_valid = 1'b0;
        wait_cycles(3);
    endtask

    logic [7:0] seq[16];
    logic [7:0] rnd_bytes[16];

    initial begin
        rst_n     = 1'b0;
        load_req  = 1'b0;
        nib_in    = 4'd0;
        nib_valid = 1'b0;
        cpu_pc    = 4'd5;
        for (int k = 0; k < 16; k++) begin
            exp_mem[k]   = 8'h00;
            obs_mem[k]   = 8'h00;
            seq[k]       = 8'(k + 1);
            rnd_bytes[k] = 8'($urandom_range(0, 255));
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_mem_address", int'(mem_address), 5);
        check("reset_hold", int'(cpu_hold), 0);
        check("reset_write", int'(mem_write), 0);
        check("reset_ready", int'(nib_ready), 0);
        check("reset_restart", int'(cpu_restart), 0);
        check("reset_err", int'(load_err), 0);

        // Full load, valid always high.
        full_load(seq, 1'b0, 1'b0);
        check_run_state("full");
        check_mem("full");

        // load_req still high: no retrigger.
        wait_cycles(6);
        check("no_retrigger_hold", int'(cpu_hold), 0);
        check("no_retrigger_restarts", obs_restarts, exp_restarts);

        // Random data with back-pressure, then the reference program again.
        full_load(rnd_bytes, 1'b1, 1'b0);
        check_run_state("rnd");
        check_mem("rnd");
        full_load(seq, 1'b1, 1'b0);
        check_run_state("bp");
        check_mem("bp");

        // Abort after the opcode nibble of word 3.
        start_load();
        for (int k = 0; k < 3; k++) send_word(k, 8'($urandom_range(0, 255)), 1'b1);
        send_nib(4'hA, 1'b1);
        @(negedge clk);
        load_req  = 1'b0;
        nib_valid = 1'b0;
        exp_restarts++;
        wait_cycles(3);
        check_run_state("abort");
        check_mem("abort");

        // Asynchronous reset while waiting for the immediate of word 7.
        start_load();
        for (int k = 0; k < 7; k++) send_word(k, 8'($urandom_range(0, 255)), 1'b0);
        send_nib(4'h3, 1'b0);
        @(negedge clk);
        rst_n     = 1'b0;
        nib_valid = 1'b0;
        load_req  = 1'b0;
        #1;
        check("areset_hold", int'(cpu_hold), 0);
        check("areset_write", int'(mem_write), 0);
        check("areset_ready", int'(nib_ready), 0);
        check("areset_addr", int'(mem_address), int'(cpu_pc));
        for (int k = 0; k < 16; k++) begin
            exp_mem[k] = 8'h00;
            obs_mem[k] = 8'h00;
        end
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(2);
        check_run_state("areset");

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum: error state holds the CPU until a new load edge.
        full_load(seq, 1'b0, 1'b1);
        check("ck_bad_err", int'(load_err), 1);
        check("ck_bad_hold", int'(cpu_hold), 1);
        check("ck_bad_no_restart", obs_restarts, exp_restarts);
        check("ck_bad_pending", exp_q.size(), 0);
        wait_cycles(5);
        check("ck_err_sticky", int'(load_err), 1);
        check("ck_hold_sticky", int'(cpu_hold), 1);
        // New edge clears the flag and a correct load restarts the CPU.
        full_load(seq, 1'b0, 1'b0);
        check("ck_good_err", int'(load_err), 0);
        check_run_state("ck_good");
        check_mem("ck_good");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/td4_mem_loader.md
# td4_mem_loader

Program loader and memory-port arbiter for the TD4 16-word × 8-bit program memory. It owns the memory's address, write-data and write-enable inputs. In run mode it passes the CPU program counter through to the memory address. In load mode it accepts a nibble-serial program stream from the host over a valid/ready handshake, writes words 0..15 in order, then restarts the CPU.

## Interface
Parameters:
- `WORDS`, default 16: number of words per load; fixed to the memory depth. The address counter is 4 bits.

Ports (reset `rst_n`, asynchronous, active-low; clock `clk`):
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `load_req` in 1: host load request, level. Its rising edge starts a load; going low aborts one.
- `nib_in` in 4: host data nibble.
- `nib_valid` in 1: `nib_in` is valid.
- `nib_ready` out 1: loader can accept a nibble.
- `cpu_pc` in 4: CPU fetch address.
- `mem_address` out 4: memory address.
- `mem_opcode_in` out 4: memory write data, opcode field.
- `mem_immediate_in` out 4: memory write data, immediate field.
- `mem_write` out 1: memory write enable.
- `cpu_hold` out 1: CPU must not advance while high.
- `cpu_restart` out 1: one-cycle pulse; CPU resets its PC to 0.
- `load_err` out 1: checksum mismatch flag. Tied to 0 without `LOADER_CHECKSUM_EN`.

## Operation
- States: RUN, GET_OP, GET_IMM, WRITE, DONE, plus GET_CK_LO, GET_CK_HI and ERR with checksum enabled.
- Reset values: state RUN, load address 0, `cpu_hold`=0, `cpu_restart`=0, `mem_write`=0, `nib_ready`=0, `load_err`=0, `load_req_q`=0.
- RUN:
  - `mem_address`=`cpu_pc`, `mem_write`=0.
  - On `load_req` high with `load_req_q` low (rising edge): load address←0, checksum←0, go to GET_OP.
- A nibble transfer occurs on a rising clk edge with `nib_valid` && `nib_ready`.
- GET_OP: `nib_ready`=1. On transfer, latch the opcode nibble and go to GET_IMM.
- GET_IMM: `nib_ready`=1. On transfer, latch the immediate nibble and go to WRITE.
- WRITE:
  - `nib_ready`=0, `mem_write`=1 for exactly one cycle.
  - `mem_address`=load address; data={immediate,opcode}.
  - checksum←checksum+{imm,op} mod 256.
  - If load address=15, go to DONE (or GET_CK_LO with checksum). Otherwise increment the address and go to GET_OP.
- DONE: `cpu_restart`=1 for one cycle, then RUN.
- In every non-RUN state: `cpu_hold`=1 and `mem_address`=load address.
- Abort:
  - In GET_OP/GET_IMM, `load_req` low takes priority over a transfer: the partial word is dropped and the state goes to DONE.
  - Already-written words stay written; unwritten words keep their previous contents.
  - WRITE always completes; abort is evaluated in the following state.
- `load_req` held high after a load does not retrigger. It must fall and rise again.
- Asynchronous reset mid-load returns to RUN immediately with no write. The memory clears itself on the same reset.
- All inputs are synchronous to `clk`. Pad synchronizers live at top level.

## Timing
- Minimum of 3 cycles per word (OP, IMM, WRITE), so a full load takes ≥48 cycles plus 1 DONE cycle. The checksum adds ≥2 cycles.
- `nib_ready` is a registered-state decode. It is never high in WRITE, DONE, RUN or ERR.
- `mem_write` is high only in WRITE and never coincides with `cpu_hold`=0.
- `mem_address` switches from the load address to `cpu_pc` in the cycle after DONE. `cpu_restart` goes high in the DONE cycle.
- Load start: `cpu_hold` rises in the cycle after the `load_req` edge is sampled.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - After word 15 the loader accepts two more nibbles, checksum low nibble then high nibble.
  - Match: DONE. Mismatch: ERR, with `load_err`=1, `cpu_hold`=1 and no restart.
  - ERR exits only on a new `load_req` rising edge. That edge clears `load_err` and enters GET_OP.
  - `load_req` low in a GET_CK state: go to DONE with no check.
- Not defined: no checksum states; `load_err` is constant 0; WRITE at address 15 goes straight to DONE.

## Test plan
- Reset check: `rst_n` low then high with `cpu_pc`=5 -> `mem_address`=5, `cpu_hold`=0, `mem_write`=0, `nib_ready`=0.
- Full load of bytes 0x01..0x10 with `nib_valid` always high -> 16 single-cycle writes at addresses 0..15 with correct {imm,op}, one `cpu_restart` pulse, then `mem_address` tracks `cpu_pc`.
- Back-pressure: `nib_valid` toggled randomly -> no nibble lost or duplicated, `nib_ready` low in WRITE, memory contents identical to the full-load case.
- Abort: drop `load_req` after the opcode nibble of word 3 -> words 0..2 written, no write to address 3, `cpu_restart` pulse, then RUN.
- Async reset asserted during GET_IMM of word 7 -> immediate return to RUN, `cpu_hold`=0, no `mem_write`.
- With `LOADER_CHECKSUM_EN`: checksum 0x88 for 0x01..0x10 -> restart. Sending 0x89 -> `load_err`=1, `cpu_hold` stays 1, and a new `load_req` edge clears `load_err`.
